// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers for the Gray counter family.
// Functions operate on a fixed maximum width; callers zero-extend and truncate.
package gray_pkg;

  localparam int MAX_W = 16;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs decode correctly: leading zero Gray bits give leading zero binary bits.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with parallel Gray load, optional saturation,
// sticky overflow/underflow flags, a one-cycle wrap pulse and a binary mirror.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_width_check
    $error("gray_counter_param: WIDTH must be in 2..16");
  end

  logic [WIDTH-1:0] cnt_p0;
  logic             ovf_p0;
  logic             unf_p0;
  logic             wrap_p0;

  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] load_bin;
  logic             at_max;
  logic             at_min;
  logic             ovf_evt;
  logic             unf_evt;

  assign load_bin = WIDTH'(gray2bin(MAX_W'(LoadVal)));
  assign at_max   = (cnt_p0 == MAX_CNT);
  assign at_min   = (cnt_p0 == '0);
  assign ovf_evt  = !Load && En && Up && at_max;
  assign unf_evt  = !Load && En && !Up && at_min;

  always_comb begin
    cnt_nxt = cnt_p0;
    if (Load) begin
      cnt_nxt = load_bin;
    end else if (En) begin
      if (Up) begin
        if (at_max) cnt_nxt = SATURATE ? cnt_p0 : '0;
        else        cnt_nxt = cnt_p0 + ONE;
      end else begin
        if (at_min) cnt_nxt = SATURATE ? cnt_p0 : MAX_CNT;
        else        cnt_nxt = cnt_p0 - ONE;
      end
    end
  end

  // Stage p0: count state and flags; a new event beats a simultaneous clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_p0  <= '0;
      ovf_p0  <= 1'b0;
      unf_p0  <= 1'b0;
      wrap_p0 <= 1'b0;
    end else begin
      cnt_p0  <= cnt_nxt;
      ovf_p0  <= ovf_evt | (ovf_p0 & ~ClrFlags);
      unf_p0  <= unf_evt | (unf_p0 & ~ClrFlags);
      wrap_p0 <= ovf_evt | unf_evt;
    end
  end

  assign Output    = WIDTH'(bin2gray(MAX_W'(cnt_p0)));
  assign Binary    = cnt_p0;
  assign Overflow  = ovf_p0;
  assign Underflow = unf_p0;
  assign Wrap      = wrap_p0;

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: three instances (3-bit wrap, 3-bit saturate, 8-bit wrap)
// share stimulus and are checked every cycle against an arithmetic reference model.
module tb_gray_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load, clr;
  logic [7:0] lv;

  logic [2:0] o_w, b_w;
  logic       ov_w, un_w, wr_w;
  logic [2:0] o_s, b_s;
  logic       ov_s, un_s, wr_s;
  logic [7:0] o_8, b_8;
  logic       ov_8, un_8, wr_8;

  gray_counter_param #(.WIDTH(3), .SATURATE(1'b0)) dut_w (
    .Clk(clk), .Reset(rst), .En(en), .Up(up), .Load(load), .LoadVal(lv[2:0]),
    .ClrFlags(clr), .Output(o_w), .Binary(b_w), .Overflow(ov_w), .Underflow(un_w), .Wrap(wr_w)
  );

  gray_counter_param #(.WIDTH(3), .SATURATE(1'b1)) dut_s (
    .Clk(clk), .Reset(rst), .En(en), .Up(up), .Load(load), .LoadVal(lv[2:0]),
    .ClrFlags(clr), .Output(o_s), .Binary(b_s), .Overflow(ov_s), .Underflow(un_s), .Wrap(wr_s)
  );

  gray_counter_param #(.WIDTH(8), .SATURATE(1'b0)) dut_8 (
    .Clk(clk), .Reset(rst), .En(en), .Up(up), .Load(load), .LoadVal(lv),
    .ClrFlags(clr), .Output(o_8), .Binary(b_8), .Overflow(ov_8), .Underflow(un_8), .Wrap(wr_8)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: counts as plain integers.
  int wd[3]  = '{3, 3, 8};
  bit sat[3] = '{1'b0, 1'b1, 1'b0};
  int cnt[3];
  bit mov[3], mun[3], mwr[3];
  bit stepped0 = 1'b0;
  bit chk_on   = 1'b0;
  bit have_prev = 1'b0;
  logic [2:0] prev_w;

  function automatic int g2b(input int g);
    int r = 0;
    for (int s = 0; s < 16; s++) r = r ^ (g >> s);
    return r;
  endfunction

  function automatic int gray(input int c);
    return c ^ (c >> 1);
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input int exp);
    logic [15:0] e;
    e = 16'(exp);
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    stepped0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int mx;
      bit eo, eu;
      mx = (1 << wd[k]) - 1;
      eo = 1'b0;
      eu = 1'b0;
      if (rst) begin
        cnt[k] = 0; mov[k] = 0; mun[k] = 0; mwr[k] = 0;
      end else begin
        if (load) begin
          cnt[k] = g2b(int'(lv) & mx);
          mwr[k] = 1'b0;
        end else if (en) begin
          if (up) begin
            if (cnt[k] == mx) begin eo = 1'b1; if (!sat[k]) cnt[k] = 0; end
            else cnt[k] = cnt[k] + 1;
          end else begin
            if (cnt[k] == 0) begin eu = 1'b1; if (!sat[k]) cnt[k] = mx; end
            else cnt[k] = cnt[k] - 1;
          end
          mwr[k] = eo | eu;
          if (k == 0) stepped0 = 1'b1;
        end else begin
          mwr[k] = 1'b0;
        end
        if (clr) begin mov[k] = 1'b0; mun[k] = 1'b0; end
        if (eo) mov[k] = 1'b1;
        if (eu) mun[k] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("w.out", 16'(o_w), gray(cnt[0]));
      cmp("w.bin", 16'(b_w), cnt[0]);
      cmp("w.ovf", 16'(ov_w), int'(mov[0]));
      cmp("w.unf", 16'(un_w), int'(mun[0]));
      cmp("w.wrap", 16'(wr_w), int'(mwr[0]));
      cmp("s.out", 16'(o_s), gray(cnt[1]));
      cmp("s.bin", 16'(b_s), cnt[1]);
      cmp("s.ovf", 16'(ov_s), int'(mov[1]));
      cmp("s.unf", 16'(un_s), int'(mun[1]));
      cmp("s.wrap", 16'(wr_s), int'(mwr[1]));
      cmp("8.out", 16'(o_8), gray(cnt[2]));
      cmp("8.bin", 16'(b_8), cnt[2]);
      cmp("8.ovf", 16'(ov_8), int'(mov[2]));
      cmp("8.unf", 16'(un_8), int'(mun[2]));
      cmp("8.wrap", 16'(wr_8), int'(mwr[2]));
      if (stepped0 && have_prev) cmp("w.hamming", 16'($countones(o_w ^ prev_w)), 1);
      prev_w    = o_w;
      have_prev = 1'b1;
    end
  end

  initial begin
    int seq1[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
    int nwrap;
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; clr = 1'b0; lv = '0;
    tick();
    chk_on = 1'b1;
    cmp("rst.out", 16'(o_w), 0);
    cmp("rst.ovf", 16'(ov_w), 0);
    cmp("rst.unf", 16'(un_w), 0);
    cmp("rst.wrap", 16'(wr_w), 0);
    cmp("rst.out8", 16'(o_8), 0);

    // Up sweep through a full 3-bit cycle.
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      cmp("t1.seq", 16'(o_w), seq1[i]);
      if (i < 7) cmp("t1.wrap_early", 16'(wr_w), 0);
      if (i == 6) cmp("t1.sat_top", 16'(o_s), 3'b100);
    end
    cmp("t1.ovf", 16'(ov_w), 1);
    cmp("t1.wrap", 16'(wr_w), 1);
    en = 1'b0;
    tick();
    cmp("t1.wrap_after", 16'(wr_w), 0);
    cmp("t1.ovf_sticky", 16'(ov_w), 1);

    // Down sweep from zero.
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    cmp("t2.out", 16'(o_w), 3'b100);
    cmp("t2.bin", 16'(b_w), 7);
    cmp("t2.unf", 16'(un_w), 1);
    cmp("t2.ovf", 16'(ov_w), 0);
    for (int i = 0; i < 7; i++) tick();
    cmp("t2.bin_end", 16'(b_w), 0);

    // Load beats count.
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0; load = 1'b1; lv = 8'b110; en = 1'b1; up = 1'b0;
    tick();
    cmp("t3.bin", 16'(b_w), 4);
    cmp("t3.out", 16'(o_w), 3'b110);
    cmp("t3.ovf", 16'(ov_w), 0);
    cmp("t3.unf", 16'(un_w), 0);
    cmp("t3.wrap", 16'(wr_w), 0);
    load = 1'b0; up = 1'b1;
    tick();
    cmp("t3.next", 16'(o_w), 3'b111);

    // Saturate mode pushes into the top.
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i >= 7) cmp("t4.hold", 16'(o_s), 3'b100);
      cmp("t4.wrap", 16'(wr_s), (i >= 8) ? 1 : 0);
    end
    cmp("t4.ovf", 16'(ov_s), 1);

    // Clear alone, then clear together with a new overflow.
    en = 1'b0; clr = 1'b1;
    tick();
    cmp("t5.clr", 16'(ov_s), 0);
    cmp("t5.bin", 16'(b_s), 7);
    en = 1'b1; up = 1'b1;
    tick();
    cmp("t5.setwins", 16'(ov_s), 1);
    cmp("t5.wrap", 16'(wr_s), 1);
    clr = 1'b0;

    // Reset mid-count wins over load and enable.
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    tick();
    cmp("t6.mid", 16'(o_w), 3'b011);
    rst = 1'b1; load = 1'b1; lv = 8'h05;
    tick();
    cmp("t6.out", 16'(o_w), 0);
    cmp("t6.ovf", 16'(ov_w), 0);
    cmp("t6.unf", 16'(un_w), 0);
    cmp("t6.wrap", 16'(wr_w), 0);
    rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    nwrap = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (wr_8 === 1'b1) nwrap++;
    end
    cmp("t6.out8", 16'(o_8), 0);
    cmp("t6.ovf8", 16'(ov_8), 1);
    cmp("t6.wraps8", 16'(nwrap), 1);
    en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
Parametrised successor to the fixed 3-bit Gray counter.
- Generalised to WIDTH bits.
- Adds up/down direction, parallel load of a Gray-coded value, and an optional saturate mode.
- Provides separate sticky Overflow and Underflow flags with explicit clear, a one-cycle wrap pulse, and a binary mirror output.
- Used as a pointer or sequence source in P-series datapath exercises and as a standalone counter under the P1 benches.

Parameters:
- WIDTH, 3, counter width in bits. Legal range is 2..16.
- SATURATE, 0, end-of-range behaviour. 0 = wrap at the end of range; 1 = hold at the end of range.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  count enable.
- Up  input  1  direction. 1 = increment, 0 = decrement. Sampled only when En=1.
- Load  input  1  parallel-load strobe.
- LoadVal  input  WIDTH  Gray-coded value to load.
- ClrFlags  input  1  clears Overflow and Underflow.
- Output  output  WIDTH  current count in Gray code.
- Binary  output  WIDTH  current count in binary.
- Overflow  output  1  sticky; set by an up-count at the maximum.
- Underflow  output  1  sticky; set by a down-count at 0.
- Wrap  output  1  one-cycle pulse following an end-of-range event.

Behaviour:
- State
  - Binary register bin[WIDTH-1:0].
  - Binary = bin.
  - Output = bin ^ (bin >> 1).
  - Both outputs are decoded from registers only; there is no combinational path from any input to any output.
- Reset (synchronous, highest priority)
  - bin = 0, so Output = 0.
  - Overflow = 0, Underflow = 0, Wrap = 0.
  - Takes effect at the first rising edge with Reset=1, including mid-count. All other inputs are ignored that cycle.
- Priority per edge: Reset > Load > En. ClrFlags is evaluated independently of Load and En.
- Load
  - bin <= gray2bin(LoadVal), where b[W-1] = g[W-1] and b[i] = b[i+1] ^ g[i].
  - En and Up are ignored that cycle.
  - Does not set any flag and does not pulse Wrap.
- Count (En=1, Load=0)
  - Up=1, bin < 2^W-1: bin <= bin+1.
  - Up=0, bin > 0: bin <= bin-1.
  - Up=1, bin = 2^W-1:
    - SATURATE=0: bin <= 0.
    - SATURATE=1: bin holds.
    - In both modes, Overflow <= 1 and Wrap <= 1 for the next cycle.
  - Up=0, bin = 0:
    - SATURATE=0: bin <= 2^W-1.
    - SATURATE=1: bin holds.
    - In both modes, Underflow <= 1 and Wrap <= 1.
  - In saturate mode, every further push into the end of range re-pulses Wrap.
- En=0 and Load=0: bin holds and Wrap <= 0.
- Flags
  - Sticky until Reset or ClrFlags.
  - If ClrFlags and a new end-of-range event occur in the same cycle, the set wins and the flag reads 1 next cycle.
  - ClrFlags never affects Wrap.
- Latency: every change is visible on the outputs one cycle after the sampling edge.
- Successive Output values differ in exactly one bit for all non-load transitions, including wrap in both directions.

Decomposition:
- Package gray_pkg holds:
  - functions bin2gray(WIDTH) and gray2bin(WIDTH);
  - localparam-style constant MAX_CNT = 2^WIDTH-1, computed inside the module from WIDTH.
- No sub-module is required. A combinational gray_to_bin helper module is acceptable in place of the package function, if the toolflow lacks package support.
- Total RTL is roughly 150 lines.

Test Plan:
1. WIDTH=3, SATURATE=0, Reset then En=1, Up=1 for 8 edges -> Output sequence 000,001,011,010,110,111,101,100,000. Overflow=1 and Wrap=1 exactly one cycle after the 8th edge; Wrap=0 thereafter.
2. From Reset, En=1, Up=0 for one edge -> Output=100, Binary=7, Underflow=1, Overflow=0. Check Hamming distance 1 on every step of an 8-step down sweep.
3. Load=1, LoadVal=110 with En=1, Up=0 in the same cycle -> Binary=4, Output=110, no flags set. Next edge with Up=1 -> Output=111.
4. WIDTH=3, SATURATE=1, Up=1 for 10 edges -> Output holds 100 from edge 7. Overflow=1; Wrap pulses on edges 8, 9 and 10.
5. With Overflow=1, assert ClrFlags alone -> Overflow=0. Then at bin=7, assert ClrFlags together with an up-count -> Overflow=1 (set wins).
6. Reset asserted mid-count at Output=011 with En=1 and Load=1 -> next cycle Output=000, all flags 0, Wrap=0. WIDTH=8 sweep of 256 up-counts -> returns to 0 with one Overflow event.
